// File: rtl/dmem_unit.sv
// Data memory unit: word/half/byte loads and stores with a fixed 2-cycle load
// response, misalignment/illegal-size rejection and a fully clearing reset.
module dmem_unit #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        MemWrite,
    input  logic [2:0]  DMType,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic        ready,
    output logic [31:0] dout,
    output logic        rvalid,
    output logic        err
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [2:0] DT_WORD = 3'd0;
    localparam logic [2:0] DT_HS   = 3'd1;
    localparam logic [2:0] DT_HU   = 3'd2;
    localparam logic [2:0] DT_BS   = 3'd3;
    localparam logic [2:0] DT_BU   = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        mem_q [DEPTH];
    logic [1:0]         off_q;
    logic [2:0]         type_q;
    logic [IDX_W-1:0]   idx_q;
    logic               bad_q;
    logic [31:0]        rdata_q;
    logic [31:0]        dout_q;
    logic               rvalid_q;
    logic               err_q;
    logic               ready_q;

    logic               ld_accept_c;
    logic               st_accept_c;
    logic               bad_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic [31:0]        sh_c;
    logic [31:0]        ext_c;
    logic [IDX_W-1:0]   widx_c;
    logic               unused_c;

    assign widx_c   = addr[IDX_W+1:2];
    assign unused_c = ^addr[31:IDX_W+2];

    assign ready  = ready_q;
    assign dout   = dout_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and request acceptance
    always_comb begin
        state_d     = state_q;
        ld_accept_c = 1'b0;
        st_accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (MemWrite) begin
                        st_accept_c = 1'b1;
                    end else begin
                        ld_accept_c = 1'b1;
                        state_d     = READ;
                    end
                end
            end
            READ:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access legality and store lane enables / replicated store data
    always_comb begin
        bad_c   = 1'b0;
        be_c    = 4'b0000;
        wdata_c = din;
        case (DMType)
            DT_WORD: begin
                bad_c = (addr[1:0] != 2'b00);
                be_c  = 4'b1111;
            end
            DT_HS, DT_HU: begin
                bad_c   = addr[0];
                be_c    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {din[15:0], din[15:0]};
            end
            DT_BS, DT_BU: begin
                be_c    = 4'(4'b0001 << addr[1:0]);
                wdata_c = {4{din[7:0]}};
            end
            default: bad_c = 1'b1;
        endcase
    end

    // Load field extraction and extension from the captured read word
    always_comb begin
        sh_c  = rdata_q >> {off_q, 3'b000};
        ext_c = '0;
        case (type_q)
            DT_WORD: ext_c = rdata_q;
            DT_HS:   ext_c = {{16{sh_c[15]}}, sh_c[15:0]};
            DT_HU:   ext_c = {16'h0000, sh_c[15:0]};
            DT_BS:   ext_c = {{24{sh_c[7]}}, sh_c[7:0]};
            DT_BU:   ext_c = {24'h000000, sh_c[7:0]};
            default: ext_c = '0;
        endcase
        if (bad_q) ext_c = '0;
    end

    // Storage: cleared on reset, lane-masked write on a legal store
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (st_accept_c && !bad_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) mem_q[widx_c][8*b +: 8] <= wdata_c[8*b +: 8];
            end
        end
    end

    // Load capture, read pipeline and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            off_q    <= '0;
            type_q   <= '0;
            idx_q    <= '0;
            bad_q    <= 1'b0;
            rdata_q  <= '0;
            dout_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= (state_d == IDLE);
            if (ld_accept_c) begin
                off_q  <= addr[1:0];
                type_q <= DMType;
                idx_q  <= widx_c;
                bad_q  <= bad_c;
            end
            if (st_accept_c && bad_c) err_q <= 1'b1;
            if (state_q == READ) rdata_q <= mem_q[idx_q];
            if (state_q == RESP) begin
                dout_q   <= ext_c;
                rvalid_q <= 1'b1;
                err_q    <= bad_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: directed vector table, reset corner sequence and
// randomized traffic checked against a byte-level memory model.
module tb_dmem_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        MemWrite;
    logic [2:0]  DMType;
    logic [31:0] addr;
    logic [31:0] din;
    logic        ready;
    logic [31:0] dout;
    logic        rvalid;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [64];

    dmem_unit #(.DEPTH(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .MemWrite (MemWrite),
        .DMType   (DMType),
        .addr     (addr),
        .din      (din),
        .ready    (ready),
        .dout     (dout),
        .rvalid   (rvalid),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          we;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_d;
        bit          exp_e;
    } vec_t;

    vec_t tbl [20];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, act, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a, input logic [2:0] t);
        if (t > 3'd4) return 1'b1;
        if (t == 3'd0 && a[1:0] != 2'b00) return 1'b1;
        if ((t == 3'd1 || t == 3'd2) && a[0]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int nbytes(input logic [2:0] t);
        if (t == 3'd0) return 4;
        if (t <= 3'd2) return 2;
        return 1;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        logic [31:0] w;
        int off;
        if (is_bad(a, t)) return;
        off = int'(a[1:0]);
        w = model_mem[a[7:2]];
        for (int k = 0; k < nbytes(t); k++) w[8*(off+k) +: 8] = d[8*k +: 8];
        model_mem[a[7:2]] = w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t);
        longint word, v, span;
        int off, nb;
        if (is_bad(a, t)) return 32'h0;
        off  = int'(a[1:0]);
        nb   = nbytes(t);
        word = longint'({32'h0, model_mem[a[7:2]]});
        span = longint'(1) << (8 * nb);
        v    = (word >> (8 * off)) % span;
        if ((t == 3'd1 || t == 3'd3) && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                            output logic ge);
        @(negedge clk);
        chk1("st_quiet_rvalid", rvalid, 1'b0);
        chk1("st_quiet_err", err, 1'b0);
        chk1("st_ready", ready, 1'b1);
        req = 1'b1; MemWrite = 1'b1; DMType = t; addr = a; din = d;
        @(negedge clk);
        req = 1'b0;
        chk1("st_ready_after", ready, 1'b1);
        chk1("st_no_rvalid", rvalid, 1'b0);
        ge = err;
    endtask

    task automatic do_load(input bit skip_wait, input logic [31:0] a, input logic [2:0] t,
                           output logic [31:0] gd, output logic ge);
        if (!skip_wait) begin
            @(negedge clk);
            chk1("ld_quiet_rvalid", rvalid, 1'b0);
            chk1("ld_quiet_err", err, 1'b0);
        end
        chk1("ld_ready", ready, 1'b1);
        req = 1'b1; MemWrite = 1'b0; DMType = t; addr = a; din = $urandom;
        @(negedge clk);
        chk1("ld_ready_read", ready, 1'b0);
        chk1("ld_rvalid_read", rvalid, 1'b0);
        req = 1'($urandom); MemWrite = 1'($urandom); DMType = 3'($urandom);
        addr = $urandom; din = $urandom;
        @(negedge clk);
        chk1("ld_ready_resp", ready, 1'b0);
        chk1("ld_rvalid_resp", rvalid, 1'b0);
        @(negedge clk);
        req = 1'b0;
        chk1("ld_rvalid_pulse", rvalid, 1'b1);
        chk1("ld_ready_back", ready, 1'b1);
        gd = dout;
        ge = err;
    endtask

    initial begin
        logic [31:0] gd, a, d;
        logic        ge;
        logic [2:0]  t;
        bit          we;

        tbl[0]  = '{1'b1, 3'd0, 32'h10,  32'h8765_4321, 32'h0,          1'b0};
        tbl[1]  = '{1'b0, 3'd0, 32'h10,  32'h0,         32'h8765_4321, 1'b0};
        tbl[2]  = '{1'b0, 3'd3, 32'h13,  32'h0,         32'hFFFF_FF87, 1'b0};
        tbl[3]  = '{1'b0, 3'd4, 32'h13,  32'h0,         32'h0000_0087, 1'b0};
        tbl[4]  = '{1'b0, 3'd1, 32'h12,  32'h0,         32'hFFFF_8765, 1'b0};
        tbl[5]  = '{1'b0, 3'd2, 32'h10,  32'h0,         32'h0000_4321, 1'b0};
        tbl[6]  = '{1'b1, 3'd3, 32'h11,  32'h0000_00AA, 32'h0,          1'b0};
        tbl[7]  = '{1'b0, 3'd0, 32'h10,  32'h0,         32'h8765_AA21, 1'b0};
        tbl[8]  = '{1'b1, 3'd1, 32'h12,  32'h0000_1234, 32'h0,          1'b0};
        tbl[9]  = '{1'b0, 3'd0, 32'h10,  32'h0,         32'h1234_AA21, 1'b0};
        tbl[10] = '{1'b1, 3'd0, 32'h02,  32'hFFFF_FFFF, 32'h0,          1'b1};
        tbl[11] = '{1'b0, 3'd0, 32'h00,  32'h0,         32'h0000_0000, 1'b0};
        tbl[12] = '{1'b0, 3'd1, 32'h11,  32'h0,         32'h0000_0000, 1'b1};
        tbl[13] = '{1'b1, 3'd0, 32'h104, 32'hDEAD_BEEF, 32'h0,          1'b0};
        tbl[14] = '{1'b0, 3'd0, 32'h004, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[15] = '{1'b0, 3'd5, 32'h10,  32'h0,         32'h0000_0000, 1'b1};
        tbl[16] = '{1'b1, 3'd6, 32'h10,  32'h0,         32'h0,          1'b1};
        tbl[17] = '{1'b0, 3'd0, 32'h10,  32'h0,         32'h1234_AA21, 1'b0};
        tbl[18] = '{1'b0, 3'd3, 32'h10,  32'h0,         32'h0000_0021, 1'b0};
        tbl[19] = '{1'b0, 3'd1, 32'h12,  32'h0,         32'h0000_1234, 1'b0};

        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;

        rst = 1'b1; req = 1'b0; MemWrite = 1'b0; DMType = 3'd0; addr = 32'h0; din = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk1("rst_ready", ready, 1'b1);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_dout", dout, 32'h0);

        // Directed vectors
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].we) begin
                do_store(tbl[i].a, tbl[i].d, tbl[i].t, ge);
                model_store(tbl[i].a, tbl[i].d, tbl[i].t);
                chk1($sformatf("vec%0d_st_err", i), ge, tbl[i].exp_e);
            end else begin
                do_load(1'b0, tbl[i].a, tbl[i].t, gd, ge);
                chk32($sformatf("vec%0d_dout", i), gd, tbl[i].exp_d);
                chk1($sformatf("vec%0d_err", i), ge, tbl[i].exp_e);
            end
        end

        // Reset while a load sits in READ; immediate load right after release
        @(negedge clk);
        req = 1'b1; MemWrite = 1'b0; DMType = 3'd0; addr = 32'h10;
        @(negedge clk);
        chk1("abort_ready_read", ready, 1'b0);
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("abort_rvalid", rvalid, 1'b0);
        chk1("abort_err", err, 1'b0);
        chk1("abort_ready", ready, 1'b1);
        chk32("abort_dout", dout, 32'h0);
        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
        do_load(1'b1, 32'h004, 3'd0, gd, ge);
        chk32("abort_mem_cleared", gd, 32'h0);
        chk1("abort_mem_err", ge, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            a[7:5] = 3'b000;
            d = $urandom;
            t = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (t == 3'd0) a[1:0] = 2'b00;
                else if (t <= 3'd2) a[0] = 1'b0;
            end
            we = 1'($urandom);
            if (we) begin
                do_store(a, d, t, ge);
                chk1($sformatf("rnd%0d_st_err", n), ge, is_bad(a, t));
                model_store(a, d, t);
            end else begin
                do_load(1'b0, a, t, gd, ge);
                chk32($sformatf("rnd%0d_dout", n), gd, model_load(a, t));
                chk1($sformatf("rnd%0d_err", n), ge, is_bad(a, t));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words of storage; word index = addr[7:2], upper address bits ignored (wrap).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  1  access request; sampled only when ready=1.
REQ-005 MemWrite  input  1  1 = store, 0 = load.
REQ-006 DMType  input  3  access size: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 illegal.
REQ-007 addr  input  32  byte address.
REQ-008 din  input  32  store data; byte/half taken from low bits.
REQ-009 ready  output  1  1 = unit can accept a request this cycle.
REQ-010 dout  output  32  load result, extended per DMType.
REQ-011 rvalid  output  1  one-cycle pulse qualifying dout.
REQ-012 err  output  1  one-cycle pulse; misaligned or illegal-DMType access rejected.

Function
REQ-013 States IDLE, READ, RESP; encoding free.
REQ-014 Request accepted when req=1 and ready=1 on the same rising edge; ready=1 only in IDLE.
REQ-015 Store accepted in IDLE: memory updated at that edge with byte enables; state stays IDLE; no rvalid; next request accepted the following cycle.
REQ-016 Store byte enables: word -> all 4 lanes; half -> lanes {addr[1],0} and {addr[1],1} get din[15:0]; byte -> lane addr[1:0] gets din[7:0]; other lanes unchanged.
REQ-017 Load accepted: IDLE -> READ; addr[1:0], DMType, index captured at acceptance; inputs ignored afterwards.
REQ-018 READ: memory word read into internal register; READ -> RESP unconditionally.
REQ-019 RESP: dout = extracted and extended field, rvalid=1 for exactly this cycle; RESP -> IDLE.
REQ-020 Load latency: acceptance edge at cycle N, rvalid=1 during cycle N+2, ready=1 again in cycle N+2 (new request acceptable at end of N+2).
REQ-021 Load extraction: word -> full word; half -> bits [16*addr[1]+15 : 16*addr[1]]; byte -> bits [8*addr[1:0]+7 : 8*addr[1:0]]; signed types sign-extend, unsigned zero-extend to 32 bits.
REQ-022 Misalignment: half with addr[0]=1, or word with addr[1:0]!=00, is misaligned.
REQ-023 Misaligned or illegal-DMType store: no memory lane written; err=1 in the cycle after acceptance; state stays IDLE.
REQ-024 Misaligned or illegal-DMType load: follows the normal IDLE->READ->RESP timing; in RESP dout=0, rvalid=1, err=1 in the same cycle.
REQ-025 err=0 in every other cycle; rvalid=0 outside RESP.
REQ-026 dout holds its last value outside RESP; only the rvalid-qualified value is meaningful.
REQ-027 Store followed immediately by load to same word: load returns the stored data (write completes before READ samples).
REQ-028 req=0 in IDLE: no state change, no memory change.

Reset
REQ-029 rst=1 at a rising edge: state -> IDLE, ready=1, rvalid=0, err=0, dout=0, all memory words cleared to 0.
REQ-030 rst takes priority over any request or in-flight load; an aborted load produces no rvalid.
REQ-031 First request is acceptable in the first cycle after rst deasserts.

Verification
REQ-032 Store word 0x8765_4321 at addr 0x10, load word at 0x10 -> rvalid two cycles after acceptance, dout=0x8765_4321, err=0.
REQ-033 With the word above: lb @0x13 -> 0xFFFF_FF87; lbu @0x13 -> 0x0000_0087; lh @0x12 -> 0xFFFF_8765; lhu @0x10 -> 0x0000_4321.
REQ-034 sb din=0xAA @0x11 then lw @0x10 -> 0x8765_AA21; sh din=0x1234 @0x12 then lw @0x10 -> 0x1234_AA21.
REQ-035 sw @0x02 -> err pulse, word 0 unchanged; lh @0x11 -> rvalid=1, err=1, dout=0.
REQ-036 Address wrap: sw 0xDEAD_BEEF @0x104, lw @0x004 -> 0xDEAD_BEEF.
REQ-037 rst asserted while in READ -> no rvalid, ready=1 next cycle, lw of any previously written word -> 0.
